mini_core_dmem_rsp: RTL and testbench

Data-memory responder for the mini core: the memory-side end of the Q103H load/store interface driven by the execute stage's registered ALU result and store data. It holds a word-organized data RAM, performs byte/half/word stores, returns aligned and sign-extended load data in Q104H, and stalls the core through `ReadyQ103H` while a multi-cycle read is in flight. Misaligned accesses are detected and dropped with an error pulse.

---
 rtl/mini_core_pkg.sv | 29 ++
 rtl/mini_core_dmem_rsp_if.sv | 27 ++
 rtl/mini_core_dmem_align.sv | 25 ++
 rtl/mini_core_dmem_rsp.sv | 134 +++++++++++++
 tb/tb_mini_core_dmem_rsp.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mini_core_pkg.sv
// Shared mini core definitions: data-memory size masks, responder FSM state,
// and the enabled DFF macro used for registered outputs.
package mini_core_pkg;

    localparam logic [3:0] DMEM_BYTE = 4'b0001;
    localparam logic [3:0] DMEM_HALF = 4'b0011;
    localparam logic [3:0] DMEM_WORD = 4'b1111;

    localparam int DMEM_MAX_RD_LAT = 4;
    localparam int DMEM_CNT_W      = $clog2(DMEM_MAX_RD_LAT);

    typedef enum logic {
        DMEM_RSP_IDLE,
        DMEM_RSP_LOAD_WAIT
    } t_dmem_rsp_state;

    // Halves need even offsets and words need offset 0; bytes are always aligned.
    function automatic logic dmem_misaligned(input logic [3:0] size, input logic [1:0] offset);
        return ((size == DMEM_HALF) && offset[0]) || ((size == DMEM_WORD) && (offset != 2'b00));
    endfunction

endpackage

`ifndef MC_DFF_EN_AR
`define MC_DFF_EN_AR(q, d, en, rv, clk, rst_n) \
    always_ff @(posedge clk or negedge rst_n) \
        if (!rst_n) q <= (rv); \
        else if (en) q <= (d);
`endif

// File: rtl/mini_core_dmem_rsp_if.sv
// Q103H load/store request and Q104H response bundle between core and data memory.
interface mini_core_dmem_rsp_if;

    logic        DMemRdEnQ103H;
    logic        DMemWrEnQ103H;
    logic [3:0]  DMemByteEnQ103H;
    logic        DMemSignExtQ103H;
    logic [31:0] DMemAddressQ103H;
    logic [31:0] DMemWrDataQ103H;
    logic        ReadyQ103H;
    logic [31:0] DMemRdDataQ104H;
    logic        DMemRdValidQ104H;
    logic        DMemAlignErrQ104H;

    modport master (
        output DMemRdEnQ103H, DMemWrEnQ103H, DMemByteEnQ103H, DMemSignExtQ103H,
               DMemAddressQ103H, DMemWrDataQ103H,
        input  ReadyQ103H, DMemRdDataQ104H, DMemRdValidQ104H, DMemAlignErrQ104H
    );

    modport slave (
        input  DMemRdEnQ103H, DMemWrEnQ103H, DMemByteEnQ103H, DMemSignExtQ103H,
               DMemAddressQ103H, DMemWrDataQ103H,
        output ReadyQ103H, DMemRdDataQ104H, DMemRdValidQ104H, DMemAlignErrQ104H
    );

endinterface

// File: rtl/mini_core_dmem_align.sv
// Load aligner: shifts the addressed byte/half down to bit 0 and sign- or zero-extends it.
module mini_core_dmem_align
    import mini_core_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [3:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_raw >> {i_offset, 3'b000};

    // NOTE: the default arm assigns o_data on every path, so no latch is inferred.
    always_comb begin
        case (i_size)
            DMEM_BYTE: o_data = {{24{i_sign & w_shifted[7]}},  w_shifted[7:0]};
            DMEM_HALF: o_data = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
            default:   o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mini_core_dmem_rsp.sv
// Data-memory responder: word RAM with byte/half/word stores, multi-cycle loads that
// stall the core through ReadyQ103H, and dropped misaligned accesses with an error pulse.
module mini_core_dmem_rsp
    import mini_core_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LAT      = 2
) (
    input  logic                 Clock,
    input  logic                 Rst,
    mini_core_dmem_rsp_if.slave  dmem
);

    localparam int                    IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(RD_LAT > 1 ? RD_LAT - 2 : 0);

    t_dmem_rsp_state       r_state;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [1:0]            r_off;
    logic [3:0]            r_size;
    logic                  r_sign;
    logic [31:0]           r_mem [DEPTH_WORDS];
    logic [31:0]           r_rd_data;
    logic                  r_rd_valid;
    logic                  r_align_err;

    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_off;
    logic [3:0]       w_size;
    logic             w_mis;
    logic             w_idle;
    logic             w_store;
    logic             w_load_go;
    logic             w_align_err;
    logic             w_rd_done;
    logic [3:0]       w_lanes;
    logic [31:0]      w_wdata;
    logic [IDX_W-1:0] w_rd_idx;
    logic [1:0]       w_rd_off;
    logic [3:0]       w_rd_size;
    logic             w_rd_sign;
    logic [31:0]      w_ext_data;
    logic             w_unused_addr;

    assign w_idx         = dmem.DMemAddressQ103H[IDX_W+1:2];
    assign w_off         = dmem.DMemAddressQ103H[1:0];
    assign w_size        = dmem.DMemByteEnQ103H;
    assign w_unused_addr = ^dmem.DMemAddressQ103H[31:IDX_W+2];
    assign w_mis         = dmem_misaligned(w_size, w_off);

    // Requests are only sampled in IDLE; a store wins when both enables are high.
    assign w_idle      = (r_state == DMEM_RSP_IDLE);
    assign w_store     = w_idle & dmem.DMemWrEnQ103H & ~w_mis;
    assign w_load_go   = w_idle & dmem.DMemRdEnQ103H & ~dmem.DMemWrEnQ103H & ~w_mis;
    assign w_align_err = w_idle & (dmem.DMemRdEnQ103H | dmem.DMemWrEnQ103H) & w_mis;
    assign w_rd_done   = (RD_LAT == 1) ? w_load_go
                                       : ((r_state == DMEM_RSP_LOAD_WAIT) && (r_cnt == '0));

    assign dmem.ReadyQ103H = ~(((RD_LAT > 1) && w_load_go) ||
                               ((r_state == DMEM_RSP_LOAD_WAIT) && (r_cnt != '0)));

    assign w_lanes = w_size << w_off;

    always_comb begin
        case (w_size)
            DMEM_BYTE: w_wdata = {4{dmem.DMemWrDataQ103H[7:0]}};
            DMEM_HALF: w_wdata = {2{dmem.DMemWrDataQ103H[15:0]}};
            default:   w_wdata = dmem.DMemWrDataQ103H;
        endcase
    end

    // NOTE: RAM has no reset branch; clearing it would turn the array into flops.
    always_ff @(posedge Clock) begin
        if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lanes[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // NOTE: state registers use <= so every branch sees the pre-edge values.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_state <= DMEM_RSP_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_off   <= '0;
            r_size  <= '0;
            r_sign  <= 1'b0;
        end else begin
            case (r_state)
                DMEM_RSP_IDLE: begin
                    if ((RD_LAT > 1) && w_load_go) begin
                        r_state <= DMEM_RSP_LOAD_WAIT;
                        r_cnt   <= CNT_INIT;
                        r_idx   <= w_idx;
                        r_off   <= w_off;
                        r_size  <= w_size;
                        r_sign  <= dmem.DMemSignExtQ103H;
                    end
                end
                DMEM_RSP_LOAD_WAIT: begin
                    if (r_cnt == '0) r_state <= DMEM_RSP_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= DMEM_RSP_IDLE;
            endcase
        end
    end

    // In LOAD_WAIT the latched request drives the read so core-side changes cannot leak in.
    assign w_rd_idx  = w_idle ? w_idx                   : r_idx;
    assign w_rd_off  = w_idle ? w_off                   : r_off;
    assign w_rd_size = w_idle ? w_size                  : r_size;
    assign w_rd_sign = w_idle ? dmem.DMemSignExtQ103H   : r_sign;

    mini_core_dmem_align u_align (
        .i_offset (w_rd_off),
        .i_size   (w_rd_size),
        .i_sign   (w_rd_sign),
        .i_raw    (r_mem[w_rd_idx]),
        .o_data   (w_ext_data)
    );

    `MC_DFF_EN_AR(r_rd_data,   w_ext_data,  w_rd_done, '0,   Clock, Rst)
    `MC_DFF_EN_AR(r_rd_valid,  w_rd_done,   1'b1,      1'b0, Clock, Rst)
    `MC_DFF_EN_AR(r_align_err, w_align_err, 1'b1,      1'b0, Clock, Rst)

    assign dmem.DMemRdDataQ104H   = r_rd_data;
    assign dmem.DMemRdValidQ104H  = r_rd_valid;
    assign dmem.DMemAlignErrQ104H = r_align_err;

endmodule

// File: tb/tb_mini_core_dmem_rsp.sv
// Directed bench for mini_core_dmem_rsp: three instances (RD_LAT 2, 4, 1) share one
// stimulus stream; each phase checks only the instance selected by sel.
module tb_mini_core_dmem_rsp;
    import mini_core_pkg::*;

    logic        Clock = 1'b0;
    logic        Rst   = 1'b0;
    logic        rd_en, wr_en, sx;
    logic [3:0]  be;
    logic [31:0] addr, wdata;

    int sel      = 0;
    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    mini_core_dmem_rsp_if if_l2 ();
    mini_core_dmem_rsp_if if_l4 ();
    mini_core_dmem_rsp_if if_l1 ();

    assign if_l2.DMemRdEnQ103H    = rd_en;
    assign if_l2.DMemWrEnQ103H    = wr_en;
    assign if_l2.DMemByteEnQ103H  = be;
    assign if_l2.DMemSignExtQ103H = sx;
    assign if_l2.DMemAddressQ103H = addr;
    assign if_l2.DMemWrDataQ103H  = wdata;

    assign if_l4.DMemRdEnQ103H    = rd_en;
    assign if_l4.DMemWrEnQ103H    = wr_en;
    assign if_l4.DMemByteEnQ103H  = be;
    assign if_l4.DMemSignExtQ103H = sx;
    assign if_l4.DMemAddressQ103H = addr;
    assign if_l4.DMemWrDataQ103H  = wdata;

    assign if_l1.DMemRdEnQ103H    = rd_en;
    assign if_l1.DMemWrEnQ103H    = wr_en;
    assign if_l1.DMemByteEnQ103H  = be;
    assign if_l1.DMemSignExtQ103H = sx;
    assign if_l1.DMemAddressQ103H = addr;
    assign if_l1.DMemWrDataQ103H  = wdata;

    mini_core_dmem_rsp #(.DEPTH_WORDS(1024), .RD_LAT(2)) u_dut_l2 (
        .Clock (Clock), .Rst (Rst), .dmem (if_l2.slave));
    mini_core_dmem_rsp #(.DEPTH_WORDS(1024), .RD_LAT(4)) u_dut_l4 (
        .Clock (Clock), .Rst (Rst), .dmem (if_l4.slave));
    mini_core_dmem_rsp #(.DEPTH_WORDS(1024), .RD_LAT(1)) u_dut_l1 (
        .Clock (Clock), .Rst (Rst), .dmem (if_l1.slave));

    logic        rdy   [3];
    logic [31:0] rdata [3];
    logic        vld   [3];
    logic        err   [3];

    assign rdy[0] = if_l2.ReadyQ103H;  assign rdata[0] = if_l2.DMemRdDataQ104H;
    assign vld[0] = if_l2.DMemRdValidQ104H;  assign err[0] = if_l2.DMemAlignErrQ104H;
    assign rdy[1] = if_l4.ReadyQ103H;  assign rdata[1] = if_l4.DMemRdDataQ104H;
    assign vld[1] = if_l4.DMemRdValidQ104H;  assign err[1] = if_l4.DMemAlignErrQ104H;
    assign rdy[2] = if_l1.ReadyQ103H;  assign rdata[2] = if_l1.DMemRdDataQ104H;
    assign vld[2] = if_l1.DMemRdValidQ104H;  assign err[2] = if_l1.DMemAlignErrQ104H;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic go_idle();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        go_idle();
        Rst = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        tick();
    endtask

    task automatic store(input string tag, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d);
        rd_en = 1'b0; wr_en = 1'b1; be = b; sx = 1'b0; addr = a; wdata = d;
        #1 check({tag, " ready"}, 32'(rdy[sel]), 32'd1);
        tick();
        go_idle();
        check({tag, " no_err"}, 32'(err[sel]), 32'd0);
    endtask

    task automatic load(input string tag, input logic [3:0] b, input logic s,
                        input logic [31:0] a, input logic [31:0] exp, input int lat);
        rd_en = 1'b1; wr_en = 1'b0; be = b; sx = s; addr = a;
        for (int i = 0; i < lat - 1; i++) begin
            #1 check({tag, " stall"}, 32'(rdy[sel]), 32'd0);
            tick();
        end
        #1 check({tag, " ready"}, 32'(rdy[sel]), 32'd1);
        if (lat > 1) check({tag, " early_valid"}, 32'(vld[sel]), 32'd0);
        tick();
        go_idle();
        check({tag, " valid"}, 32'(vld[sel]), 32'd1);
        check({tag, " data"}, rdata[sel], exp);
    endtask

    task automatic misaligned(input string tag, input logic [3:0] b, input logic [31:0] a,
                              input logic is_store);
        rd_en = ~is_store; wr_en = is_store; be = b; sx = 1'b0; addr = a;
        wdata = 32'h5555_5555;
        #1 check({tag, " ready"}, 32'(rdy[sel]), 32'd1);
        tick();
        go_idle();
        check({tag, " err"}, 32'(err[sel]), 32'd1);
        check({tag, " no_valid1"}, 32'(vld[sel]), 32'd0);
        tick();
        check({tag, " err_clear"}, 32'(err[sel]), 32'd0);
        check({tag, " no_valid2"}, 32'(vld[sel]), 32'd0);
    endtask

    initial begin
        rd_en = 1'b0; wr_en = 1'b0; be = DMEM_WORD; sx = 1'b0; addr = '0; wdata = '0;

        // Reset state on the RD_LAT=2 instance
        tick();
        tick();
        Rst = 1'b1;
        tick();
        sel = 0;
        check("rst rdata", rdata[0], 32'h0);
        check("rst valid", 32'(vld[0]), 32'd0);
        check("rst err", 32'(err[0]), 32'd0);
        check("rst ready", 32'(rdy[0]), 32'd1);

        // RD_LAT=2: word, byte and half paths
        store("sw100", DMEM_WORD, 32'h100, 32'hDEAD_BEEF);
        load ("lw100", DMEM_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, 2);
        store("sb101", DMEM_BYTE, 32'h101, 32'h0000_0080);
        load ("lb101", DMEM_BYTE, 1'b1, 32'h101, 32'hFFFF_FF80, 2);
        load ("lbu101", DMEM_BYTE, 1'b0, 32'h101, 32'h0000_0080, 2);
        load ("lw100b", DMEM_WORD, 1'b0, 32'h100, 32'hDEAD_80EF, 2);
        store("sh102", DMEM_HALF, 32'h102, 32'h0000_8001);
        load ("lh102", DMEM_HALF, 1'b1, 32'h102, 32'hFFFF_8001, 2);
        load ("lhu102", DMEM_HALF, 1'b0, 32'h102, 32'h0000_8001, 2);
        misaligned("lw102_mis", DMEM_WORD, 32'h102, 1'b0);
        misaligned("sh103_mis", DMEM_HALF, 32'h103, 1'b1);
        load ("lw100_unch", DMEM_WORD, 1'b0, 32'h100, 32'h8001_80EF, 2);
        load ("lw_alias", DMEM_WORD, 1'b0, 32'h1100, 32'h8001_80EF, 2);

        // Both enables high is a store; no read response follows
        rd_en = 1'b1; wr_en = 1'b1; be = DMEM_WORD; addr = 32'h108; wdata = 32'h0BAD_F00D;
        #1 check("rdwr ready", 32'(rdy[0]), 32'd1);
        tick();
        go_idle();
        check("rdwr no_valid1", 32'(vld[0]), 32'd0);
        tick();
        check("rdwr no_valid2", 32'(vld[0]), 32'd0);
        load ("lw108", DMEM_WORD, 1'b0, 32'h108, 32'h0BAD_F00D, 2);

        // RD_LAT=4: normal load, then reset in the second stall cycle
        sel = 1;
        do_reset();
        store("sw200", DMEM_WORD, 32'h200, 32'h1234_5678);
        load ("lw200", DMEM_WORD, 1'b0, 32'h200, 32'h1234_5678, 4);
        store("sw204", DMEM_WORD, 32'h204, 32'hCAFE_F00D);
        rd_en = 1'b1; wr_en = 1'b0; be = DMEM_WORD; sx = 1'b0; addr = 32'h204;
        #1 check("abort stall1", 32'(rdy[1]), 32'd0);
        tick();
        #1 check("abort stall2", 32'(rdy[1]), 32'd0);
        Rst = 1'b0;
        go_idle();
        #1;
        check("abort rdata", rdata[1], 32'h0);
        check("abort valid", 32'(vld[1]), 32'd0);
        check("abort ready", 32'(rdy[1]), 32'd1);
        tick();
        Rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort no_valid", 32'(vld[1]), 32'd0);
            check("abort idle", 32'(rdy[1]), 32'd1);
        end
        load ("lw204", DMEM_WORD, 1'b0, 32'h204, 32'hCAFE_F00D, 4);

        // RD_LAT=1: alternating store/load to one word, never stalls
        sel = 2;
        do_reset();
        store("l1 sw0", DMEM_WORD, 32'h300, 32'h1111_1111);
        load ("l1 lw0", DMEM_WORD, 1'b0, 32'h300, 32'h1111_1111, 1);
        store("l1 sw1", DMEM_WORD, 32'h300, 32'hA5A5_A5A5);
        load ("l1 lw1", DMEM_WORD, 1'b0, 32'h300, 32'hA5A5_A5A5, 1);
        store("l1 sw2", DMEM_WORD, 32'h300, 32'h0000_0000);
        load ("l1 lw2", DMEM_WORD, 1'b0, 32'h300, 32'h0000_0000, 1);
        store("l1 sw3", DMEM_WORD, 32'h300, 32'hFFFF_0001);
        load ("l1 lw3", DMEM_WORD, 1'b0, 32'h300, 32'hFFFF_0001, 1);
        load ("l1 lh3", DMEM_HALF, 1'b1, 32'h302, 32'hFFFF_FFFF, 1);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
